// File: rtl/sram_port_arbiter_if.sv
// Bus bundle for the SRAM port arbiter: requester handshake/response side plus
// the shared SRAM port. The arbiter uses the slave view; the environment the master view.
interface sram_port_arbiter_if #(
    parameter int NumReq    = 4,
    parameter int AddrWidth = 5,
    parameter int DataWidth = 32,
    parameter int BeWidth   = 4,
    parameter int Latency   = 1
);
    localparam int InflightWidth = $clog2(Latency + 1);

    logic [NumReq-1:0]                req_valid_i;
    logic [NumReq-1:0]                req_ready_o;
    logic [NumReq-1:0]                req_we_i;
    logic [NumReq-1:0][AddrWidth-1:0] req_addr_i;
    logic [NumReq-1:0][DataWidth-1:0] req_wdata_i;
    logic [NumReq-1:0][BeWidth-1:0]   req_be_i;
    logic [NumReq-1:0]                rsp_valid_o;
    logic [DataWidth-1:0]             rsp_rdata_o;
    logic                             mem_req_o;
    logic                             mem_we_o;
    logic [AddrWidth-1:0]             mem_addr_o;
    logic [DataWidth-1:0]             mem_wdata_o;
    logic [BeWidth-1:0]               mem_be_o;
    logic [DataWidth-1:0]             mem_rdata_i;
    logic [InflightWidth-1:0]         inflight_o;

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, mem_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, inflight_o
    );

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, mem_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, inflight_o
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one SRAM port among NumReq requesters; read
// responses are routed back through a Latency-deep requester-id shift pipeline.
module sram_port_arbiter #(
    parameter int NumReq    = 4,
    parameter int AddrWidth = 5,
    parameter int DataWidth = 32,
    parameter int BeWidth   = 4,
    parameter int Latency   = 1
) (
    input logic                clk_i,
    input logic                rst_i,
    sram_port_arbiter_if.slave bus
);
    localparam int PtrWidth = $clog2(NumReq);
    localparam int InfWidth = $clog2(Latency + 1);
    localparam logic [PtrWidth:0]   NumReqW  = (PtrWidth + 1)'(NumReq);
    localparam logic [PtrWidth-1:0] LastReq  = PtrWidth'(NumReq - 1);

    logic [PtrWidth-1:0]              rr_ptr_q, rr_ptr_d;
    logic [Latency-1:0]               pipe_vld_q, pipe_vld_d;
    logic [Latency-1:0][PtrWidth-1:0] pipe_id_q, pipe_id_d;
    logic [InfWidth-1:0]              inflight_q, inflight_d;

    logic                gnt_found;
    logic [PtrWidth-1:0] gnt_idx;
    logic                rd_issue;
    logic                rsp_fire;

    // Search from rr_ptr upward, wrapping by a single conditional subtract.
    always_comb begin : arbitrate
        logic [PtrWidth:0] sum;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        sum       = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            sum = {1'b0, rr_ptr_q} + (PtrWidth + 1)'(i);
            if (sum >= NumReqW) begin
                sum = sum - NumReqW;
            end
            if (!rst_i && !gnt_found && bus.req_valid_i[sum[PtrWidth-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = sum[PtrWidth-1:0];
            end
        end
    end

    always_comb begin : port_mux
        bus.req_ready_o = '0;
        bus.mem_req_o   = gnt_found;
        bus.mem_we_o    = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        bus.mem_be_o    = '0;
        if (gnt_found) begin
            bus.req_ready_o[gnt_idx] = 1'b1;
            bus.mem_we_o             = bus.req_we_i[gnt_idx];
            bus.mem_addr_o           = bus.req_addr_i[gnt_idx];
            bus.mem_wdata_o          = bus.req_wdata_i[gnt_idx];
            bus.mem_be_o             = bus.req_be_i[gnt_idx];
        end
    end

    always_comb begin : next_state
        rd_issue = gnt_found && !bus.req_we_i[gnt_idx];
        rsp_fire = pipe_vld_q[Latency-1];

        rr_ptr_d = rr_ptr_q;
        if (gnt_found) begin
            rr_ptr_d = (gnt_idx == LastReq) ? '0 : gnt_idx + PtrWidth'(1);
        end

        pipe_vld_d    = '0;
        pipe_id_d     = '0;
        pipe_vld_d[0] = rd_issue;
        pipe_id_d[0]  = gnt_idx;
        for (int unsigned i = 1; i < Latency; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_id_d[i]  = pipe_id_q[i-1];
        end

        inflight_d = inflight_q + InfWidth'(rd_issue) - InfWidth'(rsp_fire);
    end

    always_comb begin : responses
        bus.rsp_valid_o = '0;
        if (rsp_fire) begin
            bus.rsp_valid_o[pipe_id_q[Latency-1]] = 1'b1;
        end
        bus.rsp_rdata_o = bus.mem_rdata_i;
        bus.inflight_o  = inflight_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q   <= '0;
            pipe_vld_q <= '0;
            inflight_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            pipe_vld_q <= pipe_vld_d;
            inflight_q <= inflight_d;
        end
        pipe_id_q <= pipe_id_d;
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized and directed bench for sram_port_arbiter against a transaction-level
// reference model (round-robin search, golden memory, queue of pending reads).
module tb_sram_port_arbiter;
    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int L  = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_port_arbiter_if #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW), .BeWidth(BW), .Latency(L)) bus ();

    sram_port_arbiter #(
        .NumReq(N), .AddrWidth(AW), .DataWidth(DW), .BeWidth(BW), .Latency(L)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    // Environment SRAM: single port, read data presented L cycles after the request.
    logic [DW-1:0] sram    [2**AW];
    logic [DW-1:0] rd_pipe [L];
    assign bus.mem_rdata_i = rd_pipe[L-1];

    // Reference model state.
    typedef struct {
        int            cyc;
        int            id;
        logic [DW-1:0] data;
    } rd_t;
    rd_t           pend[$];
    logic [DW-1:0] golden [2**AW];
    int            rr;
    int            cyc;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    endtask

    task automatic set_req(input int r, input bit v, input bit we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [BW-1:0] be);
        bus.req_valid_i[r] = v;
        bus.req_we_i[r]    = we;
        bus.req_addr_i[r]  = a;
        bus.req_wdata_i[r] = d;
        bus.req_be_i[r]    = be;
    endtask

    task automatic idle();
        for (int r = 0; r < N; r++) set_req(r, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic step();
        bit             hit;
        int             g;
        int             infl;
        logic [N-1:0]   exp_rdy;
        logic [N-1:0]   exp_rsp;
        logic [DW-1:0]  exp_data;
        logic           mreq, mwe;
        logic [AW-1:0]  maddr;
        logic [DW-1:0]  mwd;
        logic [BW-1:0]  mbe;

        @(negedge clk);
        hit = 1'b0;
        g   = 0;
        for (int i = 0; i < N; i++) begin
            int k;
            k = (rr + i) % N;
            if (!hit && bus.req_valid_i[k]) begin
                hit = 1'b1;
                g   = k;
            end
        end
        if (rst) hit = 1'b0;
        exp_rdy = '0;
        if (hit) exp_rdy[g] = 1'b1;

        check("req_ready", 64'(bus.req_ready_o), 64'(exp_rdy));
        check("mem_req",   64'(bus.mem_req_o),   64'(hit));
        check("mem_we",    64'(bus.mem_we_o),    hit ? 64'(bus.req_we_i[g])    : 64'd0);
        check("mem_addr",  64'(bus.mem_addr_o),  hit ? 64'(bus.req_addr_i[g])  : 64'd0);
        check("mem_wdata", 64'(bus.mem_wdata_o), hit ? 64'(bus.req_wdata_i[g]) : 64'd0);
        check("mem_be",    64'(bus.mem_be_o),    hit ? 64'(bus.req_be_i[g])    : 64'd0);

        exp_rsp  = '0;
        exp_data = '0;
        infl     = 0;
        foreach (pend[j]) begin
            if (pend[j].cyc + L == cyc) begin
                exp_rsp[pend[j].id] = 1'b1;
                exp_data            = pend[j].data;
            end
            if (pend[j].cyc < cyc && cyc <= pend[j].cyc + L) infl++;
        end
        check("rsp_valid", 64'(bus.rsp_valid_o), 64'(exp_rsp));
        if (exp_rsp != '0) check("rsp_rdata", 64'(bus.rsp_rdata_o), 64'(exp_data));
        check("inflight", 64'(bus.inflight_o), 64'(infl));

        mreq  = bus.mem_req_o;
        mwe   = bus.mem_we_o;
        maddr = bus.mem_addr_o;
        mwd   = bus.mem_wdata_o;
        mbe   = bus.mem_be_o;

        @(posedge clk);
        for (int i = L - 1; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
        rd_pipe[0] = (mreq && !mwe) ? sram[maddr] : '0;
        if (mreq && mwe)
            for (int b = 0; b < BW; b++) if (mbe[b]) sram[maddr][8*b +: 8] = mwd[8*b +: 8];

        if (rst) begin
            rr = 0;
            pend.delete();
        end else if (hit) begin
            int a;
            a  = int'(bus.req_addr_i[g]);
            rr = (g + 1) % N;
            if (bus.req_we_i[g]) begin
                for (int b = 0; b < BW; b++)
                    if (bus.req_be_i[g][b]) golden[a][8*b +: 8] = bus.req_wdata_i[g][8*b +: 8];
            end else begin
                pend.push_back('{cyc: cyc, id: g, data: golden[a]});
            end
        end
        cyc++;
        while (pend.size() > 0 && pend[0].cyc + L < cyc) void'(pend.pop_front());
        #1;
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) begin
            sram[i]   = '0;
            golden[i] = '0;
        end
        for (int i = 0; i < L; i++) rd_pipe[i] = '0;
        rr  = 0;
        cyc = 0;
        rst = 1'b1;
        for (int r = 0; r < N; r++) set_req(r, 1'b1, 1'b0, AW'(r), '0, '0);
        @(posedge clk);
        #1;
        cyc = 1;
        // Requests held high during reset must not be granted.
        repeat (2) step();
        rst = 1'b0;
        idle();
        repeat (10) step();

        // Masked write then read-back of the same word.
        set_req(2, 1'b1, 1'b1, AW'(3), 32'hDEADBEEF, 4'b0101);
        step();
        set_req(2, 1'b1, 1'b0, AW'(3), '0, '0);
        step();
        idle();
        repeat (L + 1) step();

        // Pointer wrap: grant to the last requester, then requester 0.
        set_req(3, 1'b1, 1'b0, AW'(7), '0, '0);
        step();
        idle();
        set_req(0, 1'b1, 1'b0, AW'(3), '0, '0);
        step();
        idle();
        repeat (L) step();

        // Populate memory, then all requesters read back-to-back.
        for (int k = 0; k < 8; k++) begin
            set_req(1, 1'b1, 1'b1, AW'(k), $urandom, BW'($urandom));
            step();
        end
        for (int k = 0; k < 8; k++) begin
            for (int r = 0; r < N; r++) set_req(r, 1'b1, 1'b0, AW'($urandom_range(0, 7)), '0, '0);
            step();
        end
        idle();
        repeat (L + 1) step();

        // Continuous reads saturate the in-flight count, then drain.
        for (int k = 0; k < L + 3; k++) begin
            set_req(0, 1'b1, 1'b0, AW'(k), '0, '0);
            step();
        end
        idle();
        repeat (L + 1) step();

        // Reset one cycle after a read must drop its response.
        set_req(1, 1'b1, 1'b0, AW'(2), '0, '0);
        step();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (5) step();
        for (int r = 0; r < N; r++) set_req(r, 1'b1, 1'b0, AW'(r), '0, '0);
        step();
        idle();
        repeat (L) step();

        // Random traffic; fields of non-valid requesters are randomized too.
        for (int k = 0; k < 400; k++) begin
            for (int r = 0; r < N; r++)
                set_req(r, $urandom_range(0, 9) < 4, 1'($urandom), AW'($urandom), $urandom, BW'($urandom));
            rst = ($urandom_range(0, 49) == 0);
            step();
        end
        rst = 1'b0;
        idle();
        repeat (L + 1) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
- REQ-001: Parameter NumReq, default 4, number of requesters sharing one SRAM port; range 2..16.
- REQ-002: Parameter AddrWidth, default 5, SRAM word address width.
- REQ-003: Parameter DataWidth, default 32, data width.
- REQ-004: Parameter BeWidth, default 4, byte-enable width.
- REQ-005: Parameter Latency, default 1, SRAM read latency in cycles; range 1..8; Latency 0 is not supported.
- REQ-006: clk_i  input  1  single clock, all state updates on its rising edge.
- REQ-007: rst_i  input  1  reset, synchronous and active-high.
- REQ-008: req_valid_i  input  NumReq  per-requester request valid.
- REQ-009: req_ready_o  output  NumReq  per-requester grant; a handshake occurs when valid and ready are both high.
- REQ-010: req_we_i  input  NumReq  per-requester write enable.
- REQ-011: req_addr_i  input  NumReq x AddrWidth  per-requester address.
- REQ-012: req_wdata_i  input  NumReq x DataWidth  per-requester write data.
- REQ-013: req_be_i  input  NumReq x BeWidth  per-requester byte enable.
- REQ-014: rsp_valid_o  output  NumReq  one-hot read-response valid.
- REQ-015: rsp_rdata_o  output  DataWidth  read data, shared by all requesters.
- REQ-016: mem_req_o, mem_we_o  output  1 each  SRAM port request and write enable.
- REQ-017: mem_addr_o / mem_wdata_o / mem_be_o  output  AddrWidth / DataWidth / BeWidth  SRAM port address, write data and byte enable.
- REQ-018: mem_rdata_i  input  DataWidth  SRAM read data, valid Latency cycles after a read request.
- REQ-019: inflight_o  output  clog2(Latency+1)  number of reads issued and not yet returned.

Function
- REQ-020: Arbitration SHALL be round-robin. The search starts at rr_ptr and wraps modulo NumReq; the first requester with req_valid_i high is granted.
- REQ-021: At most one req_ready_o bit SHALL be high per cycle. req_ready_o SHALL be combinational from req_valid_i and rr_ptr. A bit is never high while its req_valid_i is low.
- REQ-022: On a handshake by requester g, rr_ptr SHALL become (g+1) mod NumReq on the next cycle. With no handshake, rr_ptr SHALL hold.
- REQ-023: mem_req_o SHALL equal the OR of req_valid_i, in the same cycle as the grant, with zero added latency.
- REQ-024: mem_we_o, mem_addr_o, mem_wdata_o and mem_be_o SHALL be the granted requester's fields.
- REQ-025: When no request is valid, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o and mem_be_o SHALL be 0.
- REQ-026: A read handshake (we low) SHALL push {valid=1, id=g} into a Latency-deep response shift pipeline. Any other cycle SHALL push {valid=0}.
- REQ-027: rsp_valid_o[id] SHALL assert for exactly one cycle, exactly Latency cycles after the read handshake.
- REQ-028: rsp_rdata_o SHALL equal mem_rdata_i combinationally and is meaningful only when a rsp_valid_o bit is high.
- REQ-029: Write handshakes SHALL produce no response. A write and a later read from the same requester SHALL keep order, because the SRAM is in-order and the pipeline is in-order.
- REQ-030: Responses SHALL have no back-pressure. Requesters SHALL accept rsp_valid_o unconditionally.
- REQ-031: Back-to-back reads from any mix of requesters SHALL be issued one per cycle. Throughput SHALL be 1 access per cycle with no bubbles.
- REQ-032: inflight_o SHALL equal the count of valid entries in the response pipeline. It increments on a read issue and decrements when a response is emitted; both in the same cycle leave it unchanged. Maximum value is Latency.
- REQ-033: A requester whose req_valid_i drops before its grant SHALL cause no SRAM access. Its fields SHALL be ignored.
- REQ-034: The rr_ptr wrap SHALL be covered: a grant to NumReq-1 sets rr_ptr to 0.

Reset
- REQ-035: While rst_i is high at a clock edge, the following SHALL all be cleared on that edge:
  - rr_ptr = 0;
  - all pipeline valid bits = 0;
  - inflight_o = 0.
- REQ-036: While rst_i is high, req_ready_o and mem_req_o SHALL be 0.
- REQ-037: Reset asserted mid-operation SHALL drop all in-flight reads. No rsp_valid_o SHALL assert for reads issued before reset, including reads whose data returns after reset release.
- REQ-038: The first cycle after reset release SHALL arbitrate normally, starting from requester 0.

Verification
- REQ-039: Requesters 0..3 all valid for reads for 8 cycles, Latency=1 -> grants 0,1,2,3,0,1,2,3, one per cycle. Each rsp_valid_o[g] fires 1 cycle after grant g, with rdata equal to the SRAM model contents.
- REQ-040: Requester 2 writes 0xDEADBEEF with be=4'b0101 to addr 3, then reads addr 3 (Latency=2) over prior value 0 -> rsp_valid_o[2] fires 2 cycles after the read handshake with rdata 0x00AD00EF. No response is emitted for the write.
- REQ-041: Only requester 3 valid, then requester 0 valid -> grant 3, then rr_ptr=0 and grant 0 (wrap check).
- REQ-042: Latency=4, reads issued on 4 consecutive cycles -> inflight_o goes 1,2,3,4 and then holds at 4 while issuing continues; with issuing stopped it drains 3,2,1,0.
- REQ-043: Latency=3, read issued, rst_i pulsed 1 cycle later -> no rsp_valid_o in the following 5 cycles; inflight_o=0 and rr_ptr=0 after reset.
- REQ-044: No valid requests -> mem_req_o=0, mem_addr_o=0, req_ready_o=0, rr_ptr unchanged over 10 cycles.
